// File: rtl/fb_fill_arbiter.sv
// fb_fill_arbiter: owns the framebuffer write port, sharing it between the
// MCU (always wins, zero latency) and a rectangle-fill engine that walks the
// rectangle in raster order and stalls on every MCU write.
// Optional feature macro: FB_FILL_ABORT_EN adds abort_i (forces IDLE, pulses err_o).
//
// state | meaning
// IDLE  | waiting for start_i; the MCU path passes straight through
// FILL  | engine writes one pixel per cycle unless the MCU holds the port
module fb_fill_arbiter #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [12:0] mcu_wa_i,
  input  logic [7:0]  mcu_wd_i,
  input  logic        mcu_we_i,
  input  logic        start_i,
  input  logic [6:0]  x0_i,
  input  logic [5:0]  y0_i,
  input  logic [6:0]  x1_i,
  input  logic [5:0]  y1_i,
  input  logic [7:0]  color_i,
`ifdef FB_FILL_ABORT_EN
  input  logic        abort_i,
`endif
  output logic [12:0] fb_wa_o,
  output logic [7:0]  fb_wd_o,
  output logic        fb_we_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [5:0] Y_MAX = 6'(ROWS - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [6:0]  cur_x_q, cur_x_d;
  logic [5:0]  cur_y_q, cur_y_d;
  logic [6:0]  x0_q, x0_d;
  logic [6:0]  x1_q, x1_d;
  logic [5:0]  y1_q, y1_d;
  logic [7:0]  color_q, color_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        eng_wr;
  logic        req_bad;
  logic        last_px;
  logic        abort;

`ifdef FB_FILL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // Write-port mux: MCU first, then the engine; never gated by reset.
  always_comb begin
    fb_wa_o = mcu_wa_i;
    fb_wd_o = mcu_wd_i;
    fb_we_o = 1'b0;
    eng_wr  = 1'b0;
    if (mcu_we_i) begin
      fb_we_o = 1'b1;
    end else if (state_q == FILL) begin
      fb_wa_o = {cur_y_q, cur_x_q};
      fb_wd_o = color_q;
      fb_we_o = 1'b1;
      eng_wr  = 1'b1;
    end
  end

  assign req_bad = (x0_i > x1_i) || (y0_i > y1_i) || (x1_i > X_MAX) || (y1_i > Y_MAX);
  assign last_px = (cur_x_q == x1_q) && (cur_y_q == y1_q);

  // Next-state logic: request validation, raster advance and completion.
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            x0_d    = x0_i;
            x1_d    = x1_i;
            y1_d    = y1_i;
            color_d = color_i;
            cur_x_d = x0_i;
            cur_y_d = y0_i;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (abort) begin
          // The current engine write (if any) still lands via the mux.
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (eng_wr) begin
          if (last_px) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (cur_x_q < x1_q) begin
            cur_x_d = cur_x_q + 7'd1;
          end else begin
            cur_x_d = x0_q;
            cur_y_d = cur_y_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = (state_q == FILL);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule
